// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD CMD-line responder.
//   rsp_type_e  - response kind offered by card logic
//   state_e     - responder line state
//   CRC7_POLY   - x^7 + x^3 + 1 feedback taps
//   FRAME_LEN   - bits per command/response frame
//   CRC7_NONE   - CRC field value sent for R3 responses
//   crc7_step() - one serial CRC7 update
package sd_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_R48  = 2'd1,
        RSP_R3   = 2'd2,
        RSP_RSVD = 2'd3
    } rsp_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WAIT_RSP,
        ST_SEND
    } state_e;

    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam int         FRAME_LEN = 48;
    localparam logic [6:0] CRC7_NONE = 7'h7F;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 accumulator, one bit per enabled cycle.
//   clk, rst  - clock, synchronous active-high reset
//   i_clr     - return the CRC to zero (wins over i_en)
//   i_en      - fold i_din into the CRC this cycle
//   i_din     - serial data bit
//   o_crc     - current CRC value
module sd_crc7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_din,
    output logic [6:0] o_crc
);
    import sd_pkg::*;

    logic [6:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= crc7_step(r_crc, i_din);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// sd_card_cmd_responder: card side of the SD CMD line.
// Receives 48-bit host commands (framing + CRC7 checked), reports them as a
// one-cycle cmd_valid / cmd_err event, then optionally sends a 48-bit
// response supplied by card logic once the NCR gap has elapsed.
//   clk, rst            - clock, synchronous active-high reset
//   tick                - SD clock rising-edge strobe; line activity advances only on it
//   cmd_i               - sampled CMD line
//   cmd_o, cmd_t        - CMD drive value and release (1 = released)
//   cmd_valid, cmd_err  - frame good / frame bad pulses
//   cmd_index, cmd_arg  - fields of the last good command
//   rsp_valid/rsp_ready - response handshake
//   rsp_type/index/arg  - response content
module sd_card_cmd_responder #(
    parameter int NcrTicks   = 2,
    parameter int RspTimeout = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_t,
    output logic        cmd_valid,
    output logic        cmd_err,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [1:0]  rsp_type,
    input  logic [5:0]  rsp_index,
    input  logic [31:0] rsp_arg
);
    import sd_pkg::*;

    localparam logic [15:0] NCR       = 16'(NcrTicks);
    localparam logic [15:0] TMO       = 16'(RspTimeout);
    localparam logic [5:0]  LAST_BIT  = 6'(FRAME_LEN - 1);
    localparam logic [5:0]  CRC_START = 6'(FRAME_LEN - 8);  // first bit position of the CRC field

    state_e     r_state,     w_state_next;
    logic [5:0] r_bit_cnt,   w_bit_cnt_next;
    logic [45:0] r_shift,    w_shift_next;     // frame bits 46..1 as they arrive
    logic [15:0] r_wait_cnt, w_wait_cnt_next;
    logic       r_have_rsp,  w_have_rsp_next;
    rsp_type_e  r_rsp_type,  w_rsp_type_next;
    logic [5:0] r_rsp_index, w_rsp_index_next;
    logic [31:0] r_rsp_arg,  w_rsp_arg_next;
    logic       r_cmd_o,     w_cmd_o_next;
    logic       r_cmd_t,     w_cmd_t_next;
    logic       r_cmd_valid, w_cmd_valid_next;
    logic       r_cmd_err,   w_cmd_err_next;
    logic [5:0] r_cmd_index, w_cmd_index_next;
    logic [31:0] r_cmd_arg,  w_cmd_arg_next;

    logic        w_rx_crc_clr, w_rx_crc_en, w_tx_crc_clr, w_tx_crc_en;
    logic [6:0]  w_rx_crc, w_tx_crc, w_crc_field;
    logic [46:0] w_rx_body;
    logic        w_rx_good;
    logic [15:0] w_wait_cnt_inc;
    logic        w_timeout, w_rsp_ready, w_rsp_accept;
    logic [5:0]  w_tx_n;
    logic [39:0] w_tx_word;
    logic        w_tx_bit;
    rsp_type_e   w_rsp_type_in;

    // A start bit is 0 and the CRC starts at 0, so the receive CRC can stay
    // cleared through the start-bit tick and pick up from bit 46.
    sd_crc7 u_rx_crc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_rx_crc_clr),
        .i_en  (w_rx_crc_en),
        .i_din (cmd_i),
        .o_crc (w_rx_crc)
    );

    // Same trick on the send side: start and transmission bits are both 0.
    sd_crc7 u_tx_crc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_tx_crc_clr),
        .i_en  (w_tx_crc_en),
        .i_din (w_tx_bit),
        .o_crc (w_tx_crc)
    );

    assign w_rx_body = {r_shift, cmd_i};
    assign w_rx_good = w_rx_body[46] && w_rx_body[0] && (w_rx_body[7:1] == w_rx_crc);

    // Counter value belonging to the current tick (end-bit tick is 0).
    assign w_wait_cnt_inc = r_wait_cnt + 16'd1;
    assign w_timeout      = (r_state == ST_WAIT_RSP) && tick && !r_have_rsp && (w_wait_cnt_inc == TMO);
    // Ready drops combinationally on the timeout tick so a late offer is never accepted.
    assign w_rsp_ready    = (r_state == ST_WAIT_RSP) && !r_have_rsp && !w_timeout;
    assign w_rsp_accept   = rsp_valid && w_rsp_ready;
    assign w_rsp_type_in  = rsp_type_e'(rsp_type);

    assign w_tx_n       = r_bit_cnt + 6'd1;
    assign w_tx_word    = {2'b00, r_rsp_index, r_rsp_arg};
    assign w_crc_field  = (r_rsp_type == RSP_R3) ? CRC7_NONE : w_tx_crc;
    assign w_tx_bit     = (w_tx_n < CRC_START) ? w_tx_word[6'd39 - w_tx_n]
                        : (w_tx_n < LAST_BIT)  ? w_crc_field[3'(6'd46 - w_tx_n)]
                        : 1'b1;
    assign w_tx_crc_clr = (r_state != ST_SEND);

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_shift_next     = r_shift;
        w_wait_cnt_next  = r_wait_cnt;
        w_have_rsp_next  = r_have_rsp;
        w_rsp_type_next  = r_rsp_type;
        w_rsp_index_next = r_rsp_index;
        w_rsp_arg_next   = r_rsp_arg;
        w_cmd_o_next     = r_cmd_o;
        w_cmd_t_next     = r_cmd_t;
        w_cmd_valid_next = 1'b0;
        w_cmd_err_next   = 1'b0;
        w_cmd_index_next = r_cmd_index;
        w_cmd_arg_next   = r_cmd_arg;
        w_rx_crc_clr     = 1'b0;
        w_rx_crc_en      = 1'b0;
        w_tx_crc_en      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_rx_crc_clr = 1'b1;
                if (tick && !cmd_i) begin
                    w_state_next   = ST_RECV;
                    w_bit_cnt_next = 6'd1;
                    w_shift_next   = '0;
                end
            end
            ST_RECV: begin
                if (tick) begin
                    w_shift_next   = w_rx_body[45:0];
                    w_bit_cnt_next = r_bit_cnt + 6'd1;
                    w_rx_crc_en    = (r_bit_cnt < CRC_START);
                    if (r_bit_cnt == LAST_BIT) begin
                        if (w_rx_good) begin
                            w_cmd_valid_next = 1'b1;
                            w_cmd_index_next = w_rx_body[45:40];
                            w_cmd_arg_next   = w_rx_body[39:8];
                            w_wait_cnt_next  = '0;
                            w_have_rsp_next  = 1'b0;
                            w_state_next     = ST_WAIT_RSP;
                        end else begin
                            w_cmd_err_next   = 1'b1;
                            w_state_next     = ST_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (tick) begin
                    w_wait_cnt_next = w_wait_cnt_inc;
                end
                if (w_rsp_accept) begin
                    w_rsp_type_next  = w_rsp_type_in;
                    w_rsp_index_next = rsp_index;
                    w_rsp_arg_next   = rsp_arg;
                    if (w_rsp_type_in == RSP_R48 || w_rsp_type_in == RSP_R3) begin
                        w_have_rsp_next = 1'b1;
                    end else begin
                        w_state_next    = ST_IDLE;
                    end
                end else if (tick && r_have_rsp && (w_wait_cnt_inc >= NCR)) begin
                    // Drive the start bit; bit_cnt tracks the bit on the line.
                    w_cmd_o_next   = 1'b0;
                    w_cmd_t_next   = 1'b0;
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_SEND;
                end else if (w_timeout) begin
                    w_state_next   = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_cmd_o_next = 1'b1;
                        w_cmd_t_next = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cmd_o_next   = w_tx_bit;
                        w_bit_cnt_next = w_tx_n;
                        w_tx_crc_en    = (w_tx_n < CRC_START);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_wait_cnt  <= '0;
            r_have_rsp  <= 1'b0;
            r_rsp_type  <= RSP_NONE;
            r_rsp_index <= '0;
            r_rsp_arg   <= '0;
            r_cmd_o     <= 1'b1;
            r_cmd_t     <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd_index <= '0;
            r_cmd_arg   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_have_rsp  <= w_have_rsp_next;
            r_rsp_type  <= w_rsp_type_next;
            r_rsp_index <= w_rsp_index_next;
            r_rsp_arg   <= w_rsp_arg_next;
            r_cmd_o     <= w_cmd_o_next;
            r_cmd_t     <= w_cmd_t_next;
            r_cmd_valid <= w_cmd_valid_next;
            r_cmd_err   <= w_cmd_err_next;
            r_cmd_index <= w_cmd_index_next;
            r_cmd_arg   <= w_cmd_arg_next;
        end
    end

    assign cmd_o     = r_cmd_o;
    assign cmd_t     = r_cmd_t;
    assign cmd_valid = r_cmd_valid;
    assign cmd_err   = r_cmd_err;
    assign cmd_index = r_cmd_index;
    assign cmd_arg   = r_cmd_arg;
    assign rsp_ready = w_rsp_ready;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench for sd_card_cmd_responder: command events and response
// frames are checked against expectations queued when stimulus is driven.
module tb_sd_card_cmd_responder;

    logic        clk = 1'b0;
    logic        rst, tick, cmd_i;
    logic        cmd_o, cmd_t, cmd_valid, cmd_err;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_type;
    logic [5:0]  rsp_index;
    logic [31:0] rsp_arg;

    sd_card_cmd_responder #(.NcrTicks(2), .RspTimeout(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .cmd_i     (cmd_i),
        .cmd_o     (cmd_o),
        .cmd_t     (cmd_t),
        .cmd_valid (cmd_valid),
        .cmd_err   (cmd_err),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_type  (rsp_type),
        .rsp_index (rsp_index),
        .rsp_arg   (rsp_arg)
    );

    always #5 clk = ~clk;

    localparam logic [47:0] CMD0      = 48'h400000000095;
    localparam logic [47:0] CMD8      = 48'h48000001AA87;
    localparam logic [47:0] CMD55_BAD = 48'h770000000067;

    typedef struct {
        logic        err;
        logic [5:0]  idx;
        logic [31:0] arg;
    } cmd_exp_t;

    cmd_exp_t    cmd_q[$];
    logic [47:0] rsp_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    logic [5:0]  last_idx = '0;
    logic [31:0] last_arg = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    logic        tick_seen = 1'b0;
    int          ticks_since = 0;
    int          cap_cnt = 0;
    logic [47:0] cap_word = '0;
    logic        rel_pending = 1'b0;

    always @(posedge clk) tick_seen <= tick;

    always @(negedge clk) begin
        if (rst) begin
            cap_cnt     = 0;
            rel_pending = 1'b0;
        end else begin
            if (cmd_valid || cmd_err) begin
                chk("pulse_expected", 64'(cmd_q.size() != 0), 64'd1);
                if (cmd_q.size() != 0) begin
                    cmd_exp_t e;
                    e = cmd_q.pop_front();
                    chk("cmd_err", 64'(cmd_err), 64'(e.err));
                    chk("cmd_valid", 64'(cmd_valid), 64'(!e.err));
                    chk("cmd_index", 64'(cmd_index), 64'(e.idx));
                    chk("cmd_arg", 64'(cmd_arg), 64'(e.arg));
                    chk("rsp_ready_at_event", 64'(rsp_ready), 64'(!e.err));
                end
                ticks_since = 0;
            end else if (tick_seen) begin
                ticks_since++;
            end
            if (tick_seen) begin
                if (rel_pending) begin
                    chk("release_cmd_t", 64'(cmd_t), 64'd1);
                    chk("release_cmd_o", 64'(cmd_o), 64'd1);
                    rel_pending = 1'b0;
                end else if (cmd_t === 1'b0) begin
                    cap_word = {cap_word[46:0], cmd_o};
                    cap_cnt++;
                    if (cap_cnt == 1) chk("start_bit_tick", 64'(ticks_since), 64'd2);
                    if (cap_cnt == 48) begin
                        chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
                        if (rsp_q.size() != 0) chk("rsp_word", 64'(cap_word), 64'(rsp_q.pop_front()));
                        $display("response frame %h", cap_word);
                        cap_cnt     = 0;
                        rel_pending = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic tick_bit(input logic b);
        @(posedge clk); #2;
        cmd_i = b;
        tick  = 1'b1;
        @(posedge clk); #2;
        tick  = 1'b0;
        cmd_i = 1'b1;
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) tick_bit(1'b1);
    endtask

    task automatic send_frame(input logic [47:0] f, input logic good);
        cmd_exp_t e;
        e.err = !good;
        if (good) begin
            last_idx = f[45:40];
            last_arg = f[39:8];
        end
        e.idx = last_idx;
        e.arg = last_arg;
        cmd_q.push_back(e);
        $display("command frame %h good=%0d", f, good);
        for (int i = 47; i >= 0; i--) tick_bit(f[i]);
    endtask

    task automatic send_partial(input logic [47:0] f, input int nbits);
        for (int i = 47; i > 47 - nbits; i--) tick_bit(f[i]);
    endtask

    task automatic respond(input logic [1:0] t, input logic [5:0] idx, input logic [31:0] arg,
                           input logic push, input logic [47:0] exp_word);
        rsp_type  = t;
        rsp_index = idx;
        rsp_arg   = arg;
        rsp_valid = 1'b1;
        @(posedge clk); #2;
        rsp_valid = 1'b0;
        if (push) rsp_q.push_back(exp_word);
        @(negedge clk);
        chk("rsp_ready_after_accept", 64'(rsp_ready), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_o"}, 64'(cmd_o), 64'd1);
        chk({tag, "_cmd_t"}, 64'(cmd_t), 64'd1);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_cmd_err"}, 64'(cmd_err), 64'd0);
        chk({tag, "_rsp_ready"}, 64'(rsp_ready), 64'd0);
        chk({tag, "_cmd_index"}, 64'(cmd_index), 64'd0);
        chk({tag, "_cmd_arg"}, 64'(cmd_arg), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        rst = 1'b1;
        tick = 1'b0;
        rsp_q.delete();
        last_idx = '0;
        last_arg = '0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; tick = 1'b0; cmd_i = 1'b1;
        rsp_valid = 1'b0; rsp_type = 2'd0; rsp_index = '0; rsp_arg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // CMD0, answered with "no response"
        send_frame(CMD0, 1'b1);
        respond(2'd0, 6'd0, 32'd0, 1'b0, 48'd0);
        idle_ticks(4);

        // CMD8 with an R7-style response
        send_frame(CMD8, 1'b1);
        respond(2'd1, 6'd8, 32'h000001AA, 1'b1, 48'h08000001AA13);
        idle_ticks(52);

        // corrupted CMD55
        send_frame(CMD55_BAD, 1'b0);
        @(negedge clk);
        chk("rsp_ready_after_err", 64'(rsp_ready), 64'd0);
        idle_ticks(4);

        // R3 response with forced CRC field
        send_frame(CMD0, 1'b1);
        respond(2'd2, 6'h3F, 32'h80FF8000, 1'b1, 48'h3F80FF8000FF);
        idle_ticks(52);

        // response timeout, with an offer arriving on the timeout tick
        send_frame(CMD8, 1'b1);
        idle_ticks(63);
        @(negedge clk);
        chk("rsp_ready_before_timeout", 64'(rsp_ready), 64'd1);
        @(posedge clk); #2;
        tick = 1'b1; cmd_i = 1'b1;
        rsp_type = 2'd1; rsp_index = 6'd8; rsp_arg = 32'h1AA; rsp_valid = 1'b1;
        @(negedge clk);
        chk("rsp_ready_on_timeout_tick", 64'(rsp_ready), 64'd0);
        @(posedge clk); #2;
        tick = 1'b0; rsp_valid = 1'b0;
        @(negedge clk);
        chk("rsp_ready_after_timeout", 64'(rsp_ready), 64'd0);
        chk("cmd_t_after_timeout", 64'(cmd_t), 64'd1);
        idle_ticks(8);
        send_frame(CMD0, 1'b1);
        respond(2'd0, 6'd0, 32'd0, 1'b0, 48'd0);
        idle_ticks(4);

        // reset in the middle of a received frame
        send_frame(CMD8, 1'b1);
        respond(2'd0, 6'd0, 32'd0, 1'b0, 48'd0);
        idle_ticks(2);
        send_partial(CMD8, 20);
        do_reset("rst_mid_recv");
        idle_ticks(2);
        send_frame(CMD0, 1'b1);
        respond(2'd0, 6'd0, 32'd0, 1'b0, 48'd0);
        idle_ticks(2);

        // reset in the middle of a response
        send_frame(CMD8, 1'b1);
        respond(2'd1, 6'd8, 32'h000001AA, 1'b0, 48'd0);
        idle_ticks(12);
        do_reset("rst_mid_send");
        idle_ticks(2);
        send_frame(CMD8, 1'b1);
        respond(2'd1, 6'd8, 32'h000001AA, 1'b1, 48'h08000001AA13);
        idle_ticks(52);

        chk("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
